// File: rtl/mips_multicycle.sv
// mips_multicycle: multicycle MIPS subset core with internal control, register file and ALU
// behind a single shared instruction/data memory port using a req/ready handshake.
module mips_multicycle #(
  parameter int          ADDR_W   = 8,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [31:0]       pc,
  output logic              retire,
  output logic              halted
);
  localparam logic [2:0] S_INIT = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
                         S_MEM = 3'd4, S_WB = 3'd5, S_HALT = 3'd6;
  logic [2:0]  r_state;
  logic [31:0] r_pc, r_ir, r_a, r_b, r_alu, r_mdr;
  logic [31:0] r_rf [32];
  logic [5:0]  w_op, w_fn;
  logic [4:0]  w_rs, w_rt, w_rd, w_wa;
  logic [31:0] w_sext, w_rop, w_alu, w_wd;
  logic        w_r, w_lw, w_sw, w_beq, w_addi, w_j, w_fn_ok, w_legal;
  assign w_op    = r_ir[31:26];
  assign w_fn    = r_ir[5:0];
  assign w_rs    = r_ir[25:21];
  assign w_rt    = r_ir[20:16];
  assign w_rd    = r_ir[15:11];
  assign w_sext  = {{16{r_ir[15]}}, r_ir[15:0]};
  assign w_r     = w_op == 6'b000000;
  assign w_lw    = w_op == 6'b100011;
  assign w_sw    = w_op == 6'b101011;
  assign w_beq   = w_op == 6'b000100;
  assign w_addi  = w_op == 6'b001000;
  assign w_j     = w_op == 6'b000010;
  assign w_fn_ok = w_fn == 6'b100000 || w_fn == 6'b100010 || w_fn == 6'b100100 ||
                   w_fn == 6'b100101 || w_fn == 6'b101010;
  assign w_legal = (w_r && w_fn_ok) || w_lw || w_sw || w_beq || w_addi || w_j;
  always_comb begin
    w_rop = w_fn == 6'b100000 ? r_a + r_b :
            w_fn == 6'b100010 ? r_a - r_b :
            w_fn == 6'b100100 ? r_a & r_b :
            w_fn == 6'b100101 ? r_a | r_b :
                                {31'd0, $signed(r_a) < $signed(r_b)};
    w_alu = w_r ? w_rop : r_a + w_sext;
    w_wa  = w_r ? w_rd : w_rt;
    w_wd  = w_lw ? r_mdr : r_alu;
  end
  // Port outputs come only from state and registers, never from mem_ready/mem_rdata.
  assign mem_req   = r_state == S_FETCH || r_state == S_MEM;
  assign mem_we    = r_state == S_MEM && w_sw;
  assign mem_addr  = r_state == S_FETCH ? r_pc[ADDR_W-1:0] :
                     r_state == S_MEM   ? r_alu[ADDR_W-1:0] : '0;
  assign mem_wdata = mem_we ? r_b : '0;
  assign pc        = r_pc;
  assign halted    = r_state == S_HALT;
  assign retire    = (r_state == S_EXEC && (w_beq || w_j)) ||
                     (r_state == S_MEM && w_sw && mem_ready) || r_state == S_WB;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_INIT;
      r_pc    <= RESET_PC;
      r_ir    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_alu   <= '0;
      r_mdr   <= '0;
      for (int i = 0; i < 32; i++) r_rf[i] <= '0;
    end else begin
      case (r_state)
        S_INIT: r_state <= S_FETCH;
        S_FETCH: if (mem_ready) begin
          r_ir    <= mem_rdata;
          r_pc    <= r_pc + 32'd4;
          r_state <= S_DECODE;
        end
        S_DECODE: begin
          r_a     <= r_rf[w_rs];
          r_b     <= r_rf[w_rt];
          r_alu   <= r_pc + {w_sext[29:0], 2'b00};
          r_state <= w_legal ? S_EXEC : S_HALT;
        end
        S_EXEC: if (w_beq || w_j) begin
          if (w_j) r_pc <= {r_pc[31:28], r_ir[25:0], 2'b00};
          else if (r_a == r_b) r_pc <= r_alu;
          r_state <= S_FETCH;
        end else begin
          r_alu   <= w_alu;
          r_state <= (w_lw || w_sw) ? S_MEM : S_WB;
        end
        S_MEM: if (mem_ready) begin
          if (w_lw) r_mdr <= mem_rdata;
          r_state <= w_lw ? S_WB : S_FETCH;
        end
        S_WB: begin
          if (w_wa != 5'd0) r_rf[w_wa] <= w_wd;
          r_state <= S_FETCH;
        end
        S_HALT: r_state <= S_HALT;
        default: r_state <= S_INIT;
      endcase
    end
  end
endmodule

// File: tb/tb_mips_multicycle.sv
// tb_mips_multicycle: directed programs against an ISA-level model with a stalling memory responder.
module tb_mips_multicycle;
  logic        clk = 0, reset = 1, mem_req, mem_we, mem_ready = 0, retire, halted;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata = 0, pc;
  mips_multicycle #(.ADDR_W(8), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .pc(pc),
    .retire(retire), .halted(halted));
  always #5 clk = ~clk;
  int n_pass = 0, n_tot = 0, cyc = 0, last = 0, acc_n = 0, wl = 0, fstall = 0, dstall = 0, n_ret = 0;
  logic busy = 0, new_txn = 0, pend = 0, init_chk = 1;
  logic [31:0] dev [64];
  logic [31:0] m_mem [64];
  logic [31:0] m_r [32];
  logic [31:0] m_pc;
  int lens[$];
  logic [31:0] pcs[$];
  logic        e_legal, e_data, e_sw;
  logic [4:0]  e_wreg, p_reg;
  logic [31:0] e_wval, e_npc, e_ea, e_sdata, s_addr, s_wd;
  logic        s_we;
  int          e_base;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_tot++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %h want %h (t=%0t)", n, a, e, $time);
  endtask
  // Architectural effect of the instruction at m_pc, from the ISA rules.
  task automatic model_eval();
    logic [31:0] ir, a, b, s;
    ir = m_mem[m_pc[7:2]];
    a = m_r[ir[25:21]];
    b = m_r[ir[20:16]];
    s = {{16{ir[15]}}, ir[15:0]};
    e_legal = 1; e_wreg = 0; e_wval = 0; e_npc = m_pc + 4; e_ea = a + s;
    e_data = 0; e_sw = 0; e_sdata = b; e_base = 4;
    case (ir[31:26])
      6'h00: begin
        e_wreg = ir[15:11];
        case (ir[5:0])
          6'h20: e_wval = a + b;
          6'h22: e_wval = a - b;
          6'h24: e_wval = a & b;
          6'h25: e_wval = a | b;
          6'h2A: e_wval = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          default: e_legal = 0;
        endcase
      end
      6'h08: begin e_wreg = ir[20:16]; e_wval = a + s; end
      6'h23: begin e_wreg = ir[20:16]; e_wval = m_mem[e_ea[7:2]]; e_data = 1; e_base = 5; end
      6'h2B: begin e_data = 1; e_sw = 1; end
      6'h04: begin e_base = 3; if (a == b) e_npc = m_pc + 4 + (s << 2); end
      6'h02: begin e_base = 3; e_npc = {e_npc[31:28], ir[25:0], 2'b00}; end
      default: e_legal = 0;
    endcase
  endtask
  task automatic model_reset();
    m_pc = 0;
    for (int i = 0; i < 32; i++) m_r[i] = 0;
    lens.delete();
    pcs.delete();
    n_ret = 0;
  endtask
  task automatic load(input int p);
    for (int i = 0; i < 64; i++) m_mem[i] = 32'hFC000000;
    if (p == 1) begin
      m_mem[0] = 32'h20010005; m_mem[1] = 32'h20020007; m_mem[2] = 32'h00221822;
      m_mem[3] = 32'h0060202A; m_mem[4] = 32'h10210002; m_mem[7] = 32'h10220005;
      m_mem[8] = 32'h00223024; m_mem[9] = 32'h00223825; m_mem[10] = 32'h00624020;
      m_mem[11] = 32'h20000009; m_mem[12] = 32'h00014820; m_mem[13] = 32'h08000000;
    end else if (p == 2) begin
      m_mem[0] = 32'h20020007; m_mem[1] = 32'h08000004; m_mem[2] = 32'h0;
      m_mem[4] = 32'hAC020008; m_mem[5] = 32'h8C050008;
    end else begin
      m_mem[0] = 32'h20020007; m_mem[1] = 32'hAC020008;
    end
    dev = m_mem;
  endtask
  task automatic do_reset(input int p);
    @(posedge clk);
    #3 reset = 1;
    busy = 0; wl = 0; mem_ready = 0;
    if (p != 0) load(p);
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 0;
  endtask
  task automatic wait_ret(input int target, input int budget);
    for (int i = 0; i < budget && n_ret < target; i++) @(posedge clk);
    chk("retire_count", n_ret, target);
  endtask
  // Memory responder plus per-cycle comparison against the model.
  always begin
    @(posedge clk);
    if (!reset && mem_req && mem_ready) begin
      if (mem_we) dev[mem_addr[7:2]] = mem_wdata;
      busy = 0;
    end else if (busy && wl > 0) wl--;
    #1;
    new_txn = 0;
    if (!reset && mem_req && !busy) begin
      busy = 1; new_txn = 1; wl = (acc_n == 0) ? fstall : dstall;
    end
    mem_ready = !reset && mem_req && busy && wl == 0;
    mem_rdata = dev[mem_addr[7:2]];
    #1;
    if (reset) begin
      last = cyc + 1; acc_n = 0; pend = 0; init_chk = 1; busy = 0; wl = 0;
    end else begin
      cyc++;
      if (init_chk) begin
        chk("init_req", mem_req, 0); chk("init_pc", pc, 0); chk("init_halted", halted, 0);
        init_chk = 0;
      end
      if (pend) begin
        chk("next_pc", pc, m_pc);
        pcs.push_back(pc);
        chk("reg_write", dut.r_rf[p_reg], m_r[p_reg]);
        pend = 0;
      end
      model_eval();
      if (new_txn) begin
        if (acc_n == 0) begin
          chk("fetch_addr", mem_addr, m_pc[7:0]); chk("fetch_we", mem_we, 0);
        end else begin
          chk("data_expected", e_data, 1); chk("data_addr", mem_addr, e_ea[7:0]);
          chk("data_we", mem_we, e_sw);
          if (e_sw) chk("data_wdata", mem_wdata, e_sdata);
        end
        acc_n++; s_addr = mem_addr; s_we = mem_we; s_wd = mem_wdata;
      end else if (busy) begin
        chk("hold_req", mem_req, 1); chk("hold_addr", mem_addr, s_addr);
        chk("hold_we", mem_we, s_we); chk("hold_wdata", mem_wdata, s_wd);
      end
      if (halted) begin
        chk("halt_illegal", e_legal, 0); chk("halt_req", mem_req, 0); chk("halt_pc", pc, m_pc + 4);
      end
      if (retire) begin
        chk("retire_legal", e_legal, 1);
        chk("cycles", cyc - last, e_base + fstall + (e_data ? dstall : 0));
        lens.push_back(cyc - last);
        if (e_wreg != 0) m_r[e_wreg] = e_wval;
        if (e_sw) m_mem[e_ea[7:2]] = e_sdata;
        m_pc = e_npc;
        p_reg = e_wreg; pend = 1; last = cyc; acc_n = 0; n_ret++;
      end
    end
  end
  initial begin
    do_reset(1);
    wait_ret(12, 300);
    repeat (2) @(posedge clk);
    #3;
    chk("p1_r3", dut.r_rf[3], 32'hFFFFFFFE); chk("p1_r4", dut.r_rf[4], 1);
    chk("p1_r6", dut.r_rf[6], 5); chk("p1_r7", dut.r_rf[7], 7);
    chk("p1_r8", dut.r_rf[8], 5); chk("p1_r9", dut.r_rf[9], 5); chk("p1_r0", dut.r_rf[0], 0);
    chk("p1_pc_first", pcs[0], 32'h4); chk("p1_pc_beq_t", pcs[4], 32'h1C);
    chk("p1_pc_beq_nt", pcs[5], 32'h20); chk("p1_pc_j", pcs[11], 32'h0);
    chk("p1_len_addi", lens[0], 4); chk("p1_len_sub", lens[2], 4); chk("p1_len_slt", lens[3], 4);
    chk("p1_len_beq", lens[4], 3); chk("p1_len_j", lens[11], 3);
    dstall = 2;
    do_reset(2);
    for (int i = 0; i < 300 && !halted; i++) @(posedge clk);
    chk("p2_halt_reached", halted, 1);
    repeat (20) @(posedge clk);
    #3;
    chk("p2_r5", dut.r_rf[5], 7); chk("p2_mem8", dev[2], 7);
    chk("p2_len_sw", lens[2], 6); chk("p2_len_lw", lens[3], 7);
    chk("p2_pc_frozen", pc, 32'h1C); chk("p2_req_idle", mem_req, 0);
    fstall = 1; dstall = 100;
    do_reset(3);
    for (int i = 0; i < 60 && !mem_we; i++) @(posedge clk);
    chk("p3_sw_pending", mem_we, 1);
    repeat (2) @(posedge clk);
    #3 reset = 1;
    busy = 0; wl = 0; mem_ready = 0;
    #1;
    chk("p3_abort_req", mem_req, 0); chk("p3_no_write", dev[2], 32'hFC000000);
    model_reset();
    dstall = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("p3_rst_r2", dut.r_rf[2], 0); chk("p3_rst_pc", pc, 0); chk("p3_rst_we", mem_we, 0);
    reset = 0;
    wait_ret(2, 100);
    repeat (2) @(posedge clk);
    #3;
    chk("p3_mem8", dev[2], 7); chk("p3_len_addi", lens[0], 5); chk("p3_len_sw", lens[1], 5);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/mips_multicycle.md
# mips_multicycle

Multicycle MIPS core that replaces the single-cycle datapath plus external control with one self-contained block: internal FSM control, internal register file and ALU, and a single shared instruction/data memory port with a request/ready handshake. Instructions take 3–5 cycles plus memory wait states, so slow synchronous memories can sit behind one port. Address width and reset vector are parametrised. Illegal instructions halt the core.

## Interface
- ADDR_W, 8, byte-address bits driven on mem_addr (address is truncated to the low ADDR_W bits)
- RESET_PC, 32'h0, PC value loaded on reset
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- mem_req  out  1  memory transfer request
- mem_we  out  1  1 = write (sw), 0 = read (fetch / lw); valid only while mem_req=1
- mem_addr  out  ADDR_W  byte address
- mem_wdata  out  32  store data (rt value); valid while mem_we=1
- mem_rdata  in  32  read data, sampled in the cycle mem_req & mem_ready
- mem_ready  in  1  transfer completes in any cycle where mem_req=1 and mem_ready=1
- pc  out  32  current PC
- retire  out  1  one-cycle pulse in the last cycle of every completed instruction
- halted  out  1  high once an illegal instruction has been decoded; sticky until reset

## Operation
- States: INIT, FETCH, DECODE, EXEC, MEM, WB, HALT.
- Reset values: state=INIT, pc=RESET_PC, IR=0, A=B=ALUOut=MDR=0, all 32 registers=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, retire=0, halted=0.
- INIT: no request; next cycle goes to FETCH.
- FETCH: mem_req=1, mem_we=0, mem_addr=pc. On ready: IR<=mem_rdata, pc<=pc+4, then DECODE. Without ready: stay; all outputs are held.
- DECODE: A<=R[rs], B<=R[rt]; ALUOut<=pc+(sext(imm)<<2). Decoded as follows:
  - Legal opcodes: R 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
  - Legal R-type funct values: add 100000, sub 100010, and 100100, or 100101, slt 101010.
  - Anything else goes to HALT.
- EXEC:
  - R-type: ALUOut<=A op B, then WB.
  - addi: ALUOut<=A+sext(imm), then WB.
  - lw/sw: ALUOut<=A+sext(imm), then MEM.
  - beq: if A==B, pc<=ALUOut; retire; then FETCH.
  - j: pc<={pc[31:28],imm26,2'b00}; retire; then FETCH.
- MEM: mem_req=1, mem_addr=ALUOut[ADDR_W-1:0].
  - lw: mem_we=0; on ready MDR<=mem_rdata, then WB.
  - sw: mem_we=1, mem_wdata=B; on ready retire, then FETCH.
- WB: writes R[rd] for R-type, R[rt] for addi and lw (MDR); retire; then FETCH.
- Register rules: writes to r0 are discarded and r0 always reads 0.
- Arithmetic rules: add, sub and addi wrap modulo 2^32 with no overflow trap. slt is a signed compare giving 1 or 0.
- HALT: halted=1, no requests, pc frozen. Only reset leaves this state.
- Misaligned addresses: the low 2 bits are passed through unchanged. Alignment is the memory's responsibility.

## Timing
- With mem_ready tied to 1, cycle counts are: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3 (FETCH through retire). Each wait cycle in FETCH or MEM adds 1.
- mem_req, mem_we, mem_addr and mem_wdata are decoded from registered state and registers only. They never depend combinationally on mem_ready or mem_rdata.
- retire is high in exactly one cycle per instruction and coincides with the state's final cycle.
- A branch or jump updates pc at the EXEC edge, so the next FETCH uses the new pc. beq not taken keeps pc+4.
- Reset asserted mid-instruction (including during a pending MEM write): mem_req drops asynchronously. No register file or pc update from the aborted instruction occurs. Execution restarts at INIT, then FETCH at RESET_PC.
- A WB write and the next instruction's DECODE read of the same register never overlap, so no bypass is needed.

## Test plan
- Reset and fetch: RESET_PC=0, ready=1, mem word0=addi $1,$0,5 (0x20010005). Required: INIT, then FETCH with addr=0, retire in cycle 4; R1=5, pc=4.
- Arithmetic: $1=5, $2=7 via addi; then sub $3,$1,$2 followed by slt $4,$3,$0. Required: R3=0xFFFFFFFE, R4=1, retire pulses 4 cycles apart.
- Memory: sw $2,8($0) then lw $5,8($0), with ready low for 2 cycles in each MEM. Required: write with addr=8, wdata=7, we=1 and outputs stable while waiting. Then R5=7; sw takes 6 cycles and lw 7.
- Branch/jump: beq $1,$1,+2 at pc=0x10. Required: pc=0x1C, 3 cycles. Then j 0x0 gives pc=0. Not-taken beq gives pc+4.
- Illegal and r0: addi $0,$0,9 leaves R0 reading 0. Opcode 0x3F: halted=1, mem_req stays 0 for 20 cycles, pc frozen.
- Reset mid-MEM: assert reset during a stalled sw. Required: mem_req falls the same cycle, no write completes, all reset values hold, restart at FETCH with pc=RESET_PC.
